// File: rtl/apb_bridge_dec.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_dec
// Description : Single-master to four-slave bridge. It registers one request
//               at a time and decodes addr[18:16] to a one-hot slave select.
//               It runs an APB-style SETUP/ACCESS handshake with a ready
//               timeout, then returns read data and an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_bridge_dec #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic                m_write,
  input  logic [DATA_W-1:0]   m_wdata,
  output logic                m_resp_valid,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_err,
  output logic [3:0]          s_sel,
  output logic                s_enable,
  output logic                s_write,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic [4*DATA_W-1:0] s_rdata,
  input  logic [3:0]          s_ready,
  input  logic [3:0]          s_err
);

  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          sel_q, sel_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [3:0]          w_dec_sel;
  logic [1:0]          w_dec_idx;
  logic                w_dec_hit;
  logic [DATA_W-1:0]   w_slv_rdata;

  // Address map shared with the upstream decoder: 1..4 map to slaves 0..3.
  always_comb begin
    w_dec_sel = 4'b0000;
    w_dec_idx = 2'd0;
    w_dec_hit = 1'b0;
    case (m_addr[18:16])
      3'd1:    begin w_dec_sel = 4'b0001; w_dec_idx = 2'd0; w_dec_hit = 1'b1; end
      3'd2:    begin w_dec_sel = 4'b0010; w_dec_idx = 2'd1; w_dec_hit = 1'b1; end
      3'd3:    begin w_dec_sel = 4'b0100; w_dec_idx = 2'd2; w_dec_hit = 1'b1; end
      3'd4:    begin w_dec_sel = 4'b1000; w_dec_idx = 2'd3; w_dec_hit = 1'b1; end
      default: begin w_dec_sel = 4'b0000; w_dec_idx = 2'd0; w_dec_hit = 1'b0; end
    endcase
  end

  // Pick the selected slave's read-data lane.
  always_comb begin
    w_slv_rdata = '0;
    case (idx_q)
      2'd0:    w_slv_rdata = s_rdata[0*DATA_W +: DATA_W];
      2'd1:    w_slv_rdata = s_rdata[1*DATA_W +: DATA_W];
      2'd2:    w_slv_rdata = s_rdata[2*DATA_W +: DATA_W];
      default: w_slv_rdata = s_rdata[3*DATA_W +: DATA_W];
    endcase
  end

  // Next-state logic: transaction sequencing, capture and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          write_d = m_write;
          wdata_d = m_wdata;
          sel_d   = w_dec_sel;
          idx_d   = w_dec_idx;
          if (w_dec_hit) begin
            state_d = ST_SETUP;
          end else begin
            // Unmapped: answer directly without touching any slave.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = 8'd0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ready takes priority over an expiring timeout.
        if (s_ready[idx_q]) begin
          err_d   = s_err[idx_q];
          rdata_d = write_q ? '0 : w_slv_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == C_TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 4'b0000;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign m_ready      = (state_q == ST_IDLE);
  assign m_resp_valid = (state_q == ST_RESP);
  assign m_rdata      = rdata_q;
  assign m_err        = err_q;
  assign s_sel        = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : 4'b0000;
  assign s_enable     = (state_q == ST_ACCESS);
  assign s_write      = write_q;
  assign s_addr       = addr_q;
  assign s_wdata      = wdata_q;

endmodule
`default_nettype wire

// File: doc/apb_bridge_dec.md
Name: apb_bridge_dec

Overview:
- Single-master to four-slave bus bridge that sits directly downstream of the address decoder stage.
- Accepts one master transaction at a time and registers the address.
- Decodes addr[18:16] into a one-hot slave select using the same map as the address decoder.
- Drives an APB-style setup/access sequence to the selected slave, waits for ready (with timeout), and returns read data and an error flag to the master.

Parameters:
- ADDR_W, 32, master/slave address width (decode always uses bits 18:16).
- DATA_W, 32, data width.
- TIMEOUT, 16, max ACCESS cycles waiting for slave ready before an error response; range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_valid  input  1  master request valid.
- m_ready  output  1  bridge can accept a request.
- m_addr  input  ADDR_W  request address.
- m_write  input  1  1 = write, 0 = read.
- m_wdata  input  DATA_W  write data.
- m_resp_valid  output  1  one-cycle response strobe.
- m_rdata  output  DATA_W  read data, valid with m_resp_valid.
- m_err  output  1  error flag, valid with m_resp_valid.
- s_sel  output  4  one-hot slave select.
- s_enable  output  1  access-phase strobe.
- s_write  output  1  registered write flag.
- s_addr  output  ADDR_W  registered address.
- s_wdata  output  DATA_W  registered write data.
- s_rdata  input  4*DATA_W  slave read data; slave n occupies bits [n*DATA_W +: DATA_W].
- s_ready  input  4  per-slave ready.
- s_err  input  4  per-slave error, sampled with ready.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, m_ready=1, m_resp_valid=0, m_rdata=0, m_err=0, s_sel=0, s_enable=0, s_write=0, s_addr=0, s_wdata=0, timeout counter=0.
- Reset mid-transaction aborts immediately. s_sel and s_enable drop asynchronously, and no response is issued.
- Decode of addr[18:16]:
  - 3'd1 -> slave0 (s_sel=0001)
  - 3'd2 -> slave1 (0010)
  - 3'd3 -> slave2 (0100)
  - 3'd4 -> slave3 (1000)
  - 0, 5, 6, 7 -> unmapped.
  - All other address bits are ignored for decode and passed through unchanged on s_addr.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - m_ready=1.
  - On m_valid&m_ready, latch addr, write and wdata into the s_* registers, and latch the decoded select and slave index.
  - Mapped address -> SETUP. Unmapped -> RESP with err=1, rdata=0; no slave is ever selected.
- SETUP:
  - m_ready=0, s_sel=one-hot, s_enable=0.
  - Lasts exactly 1 cycle, then ACCESS; timeout counter cleared.
- ACCESS:
  - s_sel held, s_enable=1.
  - Only s_ready[idx] and s_err[idx] of the selected slave are observed; other slaves' ready/err are ignored.
  - If s_ready[idx]=1:
    - capture err=s_err[idx];
    - capture rdata = (read) ? s_rdata[idx] : 0;
    - go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with ready still low, go to RESP with err=1, rdata=0.
  - A ready arriving in the same cycle the timeout expires wins: normal completion.
- RESP:
  - s_sel=0, s_enable=0.
  - m_resp_valid=1 for exactly 1 cycle with m_rdata/m_err, then IDLE.
  - m_rdata and m_err hold their values until the next RESP.
- Latency, request accepted at cycle T:
  - zero-wait slave: SETUP T+1, ACCESS T+2, m_resp_valid at T+3;
  - each wait cycle adds 1;
  - unmapped: m_resp_valid at T+1.
- m_ready=1 only in IDLE. A new request presented during RESP is not accepted until the following IDLE cycle; no back-to-back acceptance in RESP.
- m_valid deasserting after acceptance has no effect on an in-flight transaction.
- Slave-facing outputs (s_addr, s_write, s_wdata) are stable from SETUP through ACCESS.
- No combinational path from master inputs to slave outputs.

Test Plan:
- Reset/idle:
  - Assert rst mid-cycle -> all outputs zero immediately, m_ready=1 on release.
- Zero-wait read, slave2:
  - Read m_addr=0x0003_0010 with s_ready=4'b0100 always, s_rdata slave2=0xA5A5_0003 -> s_sel=0100.
  - s_enable high one cycle; m_resp_valid at T+3, m_rdata=0xA5A5_0003, m_err=0.
- Write with waits, slave0:
  - Write m_addr=0x0001_0000, m_wdata=0xDEAD_BEEF; s_ready[0] rises after 3 ACCESS cycles -> s_wdata=0xDEAD_BEEF stable throughout.
  - m_resp_valid at T+6, m_rdata=0, m_err=0.
- Unmapped addresses:
  - m_addr=0x0005_0000 and 0x0000_0000 -> s_sel never nonzero, m_resp_valid at T+1, m_err=1, m_rdata=0.
- Timeout and slave error:
  - Read slave3 (0x0004_0000) with s_ready low, TIMEOUT=16 -> m_err=1 after 16 ACCESS cycles.
  - Repeat with s_ready[3]=1 and s_err[3]=1 on the 16th cycle -> normal completion, m_err=1, data captured.
  - Ready from a non-selected slave -> ignored.
- Reset mid-ACCESS:
  - Assert rst during ACCESS to slave1 -> s_sel/s_enable drop asynchronously, no m_resp_valid, next request completes normally.
